// File: rtl/lane_pkg.sv
// lane_pkg: shared types for the road lane controller.
// State encoding, car slot record and a horizontal span test.
package lane_pkg;

    localparam int SCREEN_W = 640;
    localparam int TILE_PX  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIV    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DRAIN  = 3'd4
    } lane_state_t;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
    } car_slot_t;

    // True when lo <= p < lo + w, all in world coordinates.
    function automatic logic span_hit(
        input logic [10:0] p,
        input logic [9:0]  lo,
        input logic [6:0]  w
    );
        logic [10:0] base;
        base = {1'b0, lo};
        return (p >= base) && (p < base + {4'b0, w});
    endfunction

endpackage

// File: rtl/lane_div.sv
// lane_div: 10-bit restoring unsigned divider.
// Start loads operands; Done is high during the tenth iteration.
module lane_div
    import lane_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [9:0] Dividend,
    input  logic [9:0] Divisor,
    output logic       Done,
    output logic [9:0] Quotient
);

    logic [9:0]  q;
    logic [9:0]  r;
    logic [9:0]  d;
    logic [3:0]  cnt;
    logic [10:0] sh;
    logic [9:0]  diff;
    logic        fits;

    // One restoring step: shift in next dividend bit, trial subtract.
    always_comb begin
        sh   = {r, q[9]};
        fits = (sh >= {1'b0, d});
        diff = sh[9:0] - d;
    end

    // Iteration counter and partial remainder/quotient registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q   <= '0;
            r   <= '0;
            d   <= '0;
            cnt <= '0;
        end else if (Start) begin
            q   <= Dividend;
            r   <= '0;
            d   <= Divisor;
            cnt <= 4'd10;
        end else if (cnt != 4'd0) begin
            q   <= {q[8:0], fits};
            r   <= fits ? diff : sh[9:0];
            cnt <= cnt - 4'd1;
        end
    end

    assign Done     = (cnt == 4'd1);
    assign Quotient = q;

endmodule

// File: rtl/lane_ctrl.sv
// lane_ctrl: owns the car slots of one road lane.
// Spawns evenly spaced cars, moves them per frame, renders and hit-tests.
module lane_ctrl
    import lane_pkg::*;
#(
    parameter int TILE_Y   = 0,
    parameter int NUM_CARS = 5,
    parameter int CAR_W    = 48,
    parameter int CAR_H    = 26,
    parameter int MARGIN   = 100,
    parameter int WORLD_W  = 840
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                FrameTick,
    input  logic                SpawnValid,
    output logic                SpawnReady,
    input  logic                Despawn,
    input  logic                Direction,
    input  logic [1:0]          CarType,
    input  logic [2:0]          CarCount,
    input  logic [2:0]          CarSpeed,
    input  logic [4:0]          P1HbOffset,
    input  logic [4:0]          P2HbOffset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic [9:0]          P1X,
    input  logic [9:0]          P1Y,
    input  logic [9:0]          P2X,
    input  logic [9:0]          P2Y,
    output logic                Busy,
    output logic [NUM_CARS-1:0] ActiveMask,
    output logic                CarPixel,
    output logic [3:0]          Tile,
    output logic [5:0]          PixelX,
    output logic [4:0]          PixelY,
    output logic                P1Hit,
    output logic                P2Hit
);

    // Lane top row; two's complement so low lanes may sit above row 0.
    localparam logic [11:0] SPAWN_Y = 12'(TILE_PX * TILE_Y - (CAR_H - TILE_PX));

    lane_state_t state;
    car_slot_t   slot [NUM_CARS];
    logic [2:0]  cnt;
    logic [2:0]  idx;
    logic [2:0]  cnt_in;
    logic        dir;
    logic [1:0]  typ;
    logic [2:0]  spd;
    logic [9:0]  acc;
    logic [9:0]  spacing;
    logic [9:0]  dividend;
    logic [9:0]  divisor;
    logic        div_start;
    logic        div_done;
    logic        drain;
    logic [10:0] sum  [NUM_CARS];
    logic [9:0]  nx   [NUM_CARS];
    logic        wrap [NUM_CARS];
    logic [NUM_CARS-1:0] mask;
    logic [10:0] wx;
    logic [10:0] h1x;
    logic [10:0] h2x;
    logic        cov;
    logic [5:0]  off;
    logic [4:0]  py;
    logic [1:0]  col;
    logic        hit1;
    logic        hit2;

    function automatic logic row_hit(input logic [9:0] y);
        logic [11:0] dy;
        dy = {2'b00, y} - SPAWN_Y;
        return !dy[11] && (dy[10:0] < 11'(CAR_H));
    endfunction

    // Spawn operands: clamp the request and form the spacing division.
    always_comb begin
        cnt_in    = (CarCount > 3'(NUM_CARS)) ? 3'(NUM_CARS) : CarCount;
        dividend  = 10'(SCREEN_W - CAR_W * int'(cnt_in));
        divisor   = {7'b0, cnt_in} + 10'd1;
        div_start = (state == ST_IDLE) && SpawnValid;
        drain     = (state == ST_DRAIN) || Despawn;
    end

    lane_div u_div (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (div_start),
        .Dividend (dividend),
        .Divisor  (divisor),
        .Done     (div_done),
        .Quotient (spacing)
    );

    // Next position of every slot, with seam wrap detection.
    always_comb begin
        for (int i = 0; i < NUM_CARS; i++) begin
            sum[i]  = {1'b0, slot[i].x} + {8'b0, spd};
            mask[i] = slot[i].active;
            if (!dir) begin
                wrap[i] = (sum[i] >= 11'(WORLD_W));
                nx[i]   = wrap[i] ? 10'(sum[i] - 11'(WORLD_W)) : sum[i][9:0];
            end else begin
                wrap[i] = (slot[i].x < {7'b0, spd});
                nx[i]   = wrap[i]
                        ? 10'({1'b0, slot[i].x} + 11'(WORLD_W) - {8'b0, spd})
                        : slot[i].x - {7'b0, spd};
            end
        end
    end

    // Lane FSM: spawn, divide, load slots, move, drain.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            acc   <= '0;
            dir   <= 1'b0;
            typ   <= '0;
            spd   <= '0;
            for (int i = 0; i < NUM_CARS; i++) slot[i] <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (SpawnValid) begin
                        cnt   <= cnt_in;
                        dir   <= Direction;
                        typ   <= CarType;
                        spd   <= CarSpeed;
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (Despawn) begin
                        for (int i = 0; i < NUM_CARS; i++) slot[i].active <= 1'b0;
                        state <= ST_IDLE;
                    end else if (div_done) begin
                        acc   <= 10'(MARGIN);
                        idx   <= '0;
                        state <= (cnt == 3'd0) ? ST_ACTIVE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (Despawn) begin
                        for (int i = 0; i < NUM_CARS; i++) slot[i].active <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        for (int i = 0; i < NUM_CARS; i++) begin
                            if (3'(i) == idx) begin
                                slot[i].x      <= acc + spacing;
                                slot[i].active <= 1'b1;
                            end
                        end
                        acc <= acc + spacing + 10'(CAR_W);
                        idx <= idx + 3'd1;
                        if (idx == cnt - 3'd1) state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE, ST_DRAIN: begin
                    if (state == ST_DRAIN && mask == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        if (FrameTick) begin
                            for (int i = 0; i < NUM_CARS; i++) begin
                                if (slot[i].active) begin
                                    slot[i].x <= nx[i];
                                    if (drain && wrap[i]) slot[i].active <= 1'b0;
                                end
                            end
                        end
                        if (Despawn) state <= ST_DRAIN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pixel cover and player overlap; lowest covering slot wins.
    always_comb begin
        wx   = {1'b0, DrawX} + 11'(MARGIN);
        h1x  = {1'b0, P1X} + 11'(MARGIN) + {6'b0, P1HbOffset};
        h2x  = {1'b0, P2X} + 11'(MARGIN) + {6'b0, P2HbOffset};
        py   = 5'({2'b00, DrawY} - SPAWN_Y);
        cov  = 1'b0;
        off  = '0;
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (slot[i].active && row_hit(DrawY)
                && span_hit(wx, slot[i].x, 7'(CAR_W))) begin
                cov = 1'b1;
                off = 6'(wx - {1'b0, slot[i].x});
            end
            if (slot[i].active && row_hit(P1Y)
                && span_hit(h1x, slot[i].x, 7'(CAR_W))) hit1 = 1'b1;
            if (slot[i].active && row_hit(P2Y)
                && span_hit(h2x, slot[i].x, 7'(CAR_W))) hit2 = 1'b1;
        end
        col = 2'(off / 6'(TILE_PX));
        if (dir) col = 2'd2 - col;
    end

    // Registered render and hit outputs for the renderer and game FSM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CarPixel <= 1'b0;
            Tile     <= '0;
            PixelX   <= '0;
            PixelY   <= '0;
            P1Hit    <= 1'b0;
            P2Hit    <= 1'b0;
        end else begin
            CarPixel <= cov;
            Tile     <= cov ? {typ, col} : 4'd0;
            PixelX   <= cov ? off : 6'd0;
            PixelY   <= cov ? py : 5'd0;
            P1Hit    <= hit1;
            P2Hit    <= hit2;
        end
    end

    assign ActiveMask = mask;
    assign Busy       = (state != ST_IDLE);
    assign SpawnReady = (state == ST_IDLE);

endmodule

// File: tb/tb_lane_ctrl.sv
// tb_lane_ctrl: scoreboard bench for the lane controller.
// Expectations are queued with stimulus and checked on DUT output.
module tb_lane_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       FrameTick = 1'b0;
    logic       SpawnValid = 1'b0;
    logic       SpawnReady;
    logic       Despawn = 1'b0;
    logic       Direction = 1'b0;
    logic [1:0] CarType = '0;
    logic [2:0] CarCount = '0;
    logic [2:0] CarSpeed = '0;
    logic [4:0] P1HbOffset = '0;
    logic [4:0] P2HbOffset = '0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [9:0] P1X = '0;
    logic [9:0] P1Y = '0;
    logic [9:0] P2X = '0;
    logic [9:0] P2Y = '0;
    logic       Busy;
    logic [4:0] ActiveMask;
    logic       CarPixel;
    logic [3:0] Tile;
    logic [5:0] PixelX;
    logic [4:0] PixelY;
    logic       P1Hit;
    logic       P2Hit;

    lane_ctrl #(.TILE_Y(10), .NUM_CARS(5)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .FrameTick  (FrameTick),
        .SpawnValid (SpawnValid),
        .SpawnReady (SpawnReady),
        .Despawn    (Despawn),
        .Direction  (Direction),
        .CarType    (CarType),
        .CarCount   (CarCount),
        .CarSpeed   (CarSpeed),
        .P1HbOffset (P1HbOffset),
        .P2HbOffset (P2HbOffset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .P1X        (P1X),
        .P1Y        (P1Y),
        .P2X        (P2X),
        .P2Y        (P2Y),
        .Busy       (Busy),
        .ActiveMask (ActiveMask),
        .CarPixel   (CarPixel),
        .Tile       (Tile),
        .PixelX     (PixelX),
        .PixelY     (PixelY),
        .P1Hit      (P1Hit),
        .P2Hit      (P2Hit)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            e.tag = "sb_underflow";
            e.v   = 'x;
        end else begin
            e = sb.pop_front();
        end
        chk(e.tag, obs, e.v);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
    endtask

    task automatic frames(input int n);
        FrameTick = 1'b1;
        repeat (n) @(posedge Clk);
        #1;
        FrameTick = 1'b0;
    endtask

    task automatic probe(input string tag, input int dx, input int dy,
                         input int pix, input int px, input int py, input int tile);
        push({tag, "_pix"}, pix);
        push({tag, "_px"}, px);
        push({tag, "_py"}, py);
        push({tag, "_tile"}, tile);
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        cyc();
        pop_chk(CarPixel);
        pop_chk(PixelX);
        pop_chk(PixelY);
        pop_chk(Tile);
    endtask

    task automatic spawn(input string tag, input int cnt, input bit dir,
                         input int spd, input int typ);
        int ld;
        int n;
        ld = (cnt > 5) ? 5 : cnt;
        n  = 0;
        while (SpawnReady !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        push({tag, "_rdy"}, 1);
        pop_chk(SpawnReady);
        CarCount   = 3'(cnt);
        Direction  = dir;
        CarSpeed   = 3'(spd);
        CarType    = 2'(typ);
        SpawnValid = 1'b1;
        cyc();
        SpawnValid = 1'b0;
        push({tag, "_busy"}, 1);
        pop_chk(Busy);
        repeat (9 + ld) begin
            push({tag, "_nrdy"}, 0);
            cyc();
            pop_chk(SpawnReady);
        end
        push({tag, "_mask_part"}, (1 << (ld - 1)) - 1);
        pop_chk(ActiveMask);
        push({tag, "_mask_full"}, (1 << ld) - 1);
        cyc();
        pop_chk(ActiveMask);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       mx[3];
        logic [2:0] mm;
        int       n;

        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        push("rst_busy", 0);  pop_chk(Busy);
        push("rst_rdy", 1);   pop_chk(SpawnReady);
        push("rst_mask", 0);  pop_chk(ActiveMask);
        push("rst_pix", 0);   pop_chk(CarPixel);
        push("rst_tile", 0);  pop_chk(Tile);
        push("rst_p1", 0);    pop_chk(P1Hit);
        push("rst_p2", 0);    pop_chk(P2Hit);

        // Three cars: spacing 124, X = 224, 396, 568.
        spawn("sp3", 3, 1'b0, 7, 2);
        probe("r0", 124, 150, 1, 0, 0, 8);
        probe("r47", 171, 150, 1, 47, 0, 10);
        probe("rgap", 172, 150, 0, 0, 0, 0);
        probe("ry25", 296, 175, 1, 0, 25, 8);
        probe("ry26", 296, 176, 0, 0, 0, 0);
        probe("ryneg", 296, 149, 0, 0, 0, 0);

        P1X = 10'd120; P1HbOffset = 5'd4; P1Y = 10'd150;
        P2X = 10'd271; P2HbOffset = 5'd1; P2Y = 10'd150;
        push("hit1_in", 1); push("hit2_gap", 0);
        cyc();
        pop_chk(P1Hit); pop_chk(P2Hit);
        P1Y = 10'd176;
        P2X = 10'd296; P2HbOffset = 5'd0;
        push("hit1_below", 0); push("hit2_edge", 1);
        cyc();
        pop_chk(P1Hit); pop_chk(P2Hit);

        // Drain: each slot clears on the tick that would wrap it.
        mx[0] = 224; mx[1] = 396; mx[2] = 568; mm = 3'b111;
        Despawn = 1'b1;
        cyc();
        Despawn = 1'b0;
        n = 0;
        while (mm != 3'b000 && n < 200) begin
            for (int i = 0; i < 3; i++) begin
                if (mm[i]) begin
                    if (mx[i] + 7 >= 840) mm[i] = 1'b0;
                    else mx[i] = mx[i] + 7;
                end
            end
            push("drain_mask", {29'b0, mm});
            FrameTick = 1'b1;
            cyc();
            FrameTick = 1'b0;
            pop_chk(ActiveMask);
            n++;
        end
        push("drain_busy_hold", 1); pop_chk(Busy);
        cyc();
        push("drain_busy_drop", 0); pop_chk(Busy);
        push("drain_rdy", 1);       pop_chk(SpawnReady);

        // Clamp 7 -> 5 cars: spacing 66, X0 = 166, X4 = 622.
        spawn("clamp", 7, 1'b0, 4, 1);
        probe("c0", 66, 150, 1, 0, 0, 4);
        probe("c0m", 65, 150, 0, 0, 0, 0);
        probe("c4", 522, 150, 1, 0, 0, 4);
        probe("c4m", 521, 150, 0, 0, 0, 0);

        // Right wrap: X4 reaches 838, then 838 + 4 - 840 = 2.
        frames(54);
        probe("wr838", 738, 150, 1, 0, 0, 4);
        frames(1);
        probe("wr_gone", 738, 150, 0, 0, 0, 0);
        frames(25);
        probe("wr102", 2, 150, 1, 0, 0, 4);
        probe("wr486", 386, 150, 1, 0, 0, 4);

        // Left wrap: X0 166 -> 1 after 55 frames, then 1 + 840 - 3 = 838.
        do_reset();
        spawn("left", 5, 1'b1, 3, 3);
        frames(56);
        probe("wl838", 738, 150, 1, 0, 0, 14);
        probe("wl112", 12, 150, 1, 0, 0, 14);
        probe("wl159", 59, 150, 1, 47, 0, 12);
        probe("wl837", 737, 150, 0, 0, 0, 0);

        // Reset in the middle of LOAD.
        do_reset();
        DrawX = 10'd66;
        DrawY = 10'd150;
        CarCount = 3'd5; Direction = 1'b0; CarSpeed = 3'd1; CarType = 2'd0;
        SpawnValid = 1'b1;
        cyc();
        SpawnValid = 1'b0;
        repeat (12) cyc();
        push("mid_mask", 3); pop_chk(ActiveMask);
        push("mid_pix", 1);  pop_chk(CarPixel);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        push("mr_mask", 0); pop_chk(ActiveMask);
        push("mr_busy", 0); pop_chk(Busy);
        push("mr_rdy", 1);  pop_chk(SpawnReady);
        push("mr_pix", 0);  pop_chk(CarPixel);
        cyc();
        push("mr_pix2", 0); pop_chk(CarPixel);

        // Despawn while dividing.
        CarCount = 3'd2;
        SpawnValid = 1'b1;
        cyc();
        SpawnValid = 1'b0;
        cyc();
        cyc();
        push("dd_busy_div", 1); pop_chk(Busy);
        Despawn = 1'b1;
        cyc();
        Despawn = 1'b0;
        push("dd_busy", 0); pop_chk(Busy);
        push("dd_rdy", 1);  pop_chk(SpawnReady);
        push("dd_mask", 0); pop_chk(ActiveMask);
        repeat (12) cyc();
        push("dd_mask_late", 0); pop_chk(ActiveMask);
        push("dd_pix_late", 0);  pop_chk(CarPixel);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
